// File: rtl/dataint_pkg.sv
// -----------------------------------------------------------------------------
// dataint_pkg
// Shared definitions for the chunked-parity data-integrity blocks. The chunk
// boundary helpers are the single source of truth used by both the parity
// generator and the checker, so the two always agree on chunk layout.
//
// Contents:
//   parity_type_e : PARITY_ODD (1'b0) / PARITY_EVEN (1'b1)
//   chunk_lo()    : lowest bit index of chunk idx
//   chunk_hi()    : highest bit index of chunk idx (last chunk absorbs remainder)
// -----------------------------------------------------------------------------
package dataint_pkg;

    typedef enum logic {
        PARITY_ODD  = 1'b0,
        PARITY_EVEN = 1'b1
    } parity_type_e;

    function automatic int chunk_lo(input int width, input int chunks, input int idx);
        return idx * (width / chunks);
    endfunction

    // The last chunk runs up to width-1 so that WIDTH need not be a multiple
    // of CHUNKS; the leftover bits land in the top chunk.
    function automatic int chunk_hi(input int width, input int chunks, input int idx);
        if (idx == chunks - 1) begin
            return width - 1;
        end
        return (idx + 1) * (width / chunks) - 1;
    endfunction

endpackage

// File: rtl/dataint_parity_chk_pipe_if.sv
// -----------------------------------------------------------------------------
// dataint_parity_chk_pipe_if
// Stream bundle for the parity checker: the upstream valid/ready beat with its
// received parity and the downstream valid/ready beat with its per-chunk
// error flags. Signal names are from the checker's point of view.
//
// Signals:
//   i_valid, o_ready, i_data[WIDTH], i_parity[CHUNKS]  upstream side
//   o_valid, i_ready, o_data[WIDTH], o_error[CHUNKS]   downstream side
// Modports:
//   slave  : the checker
//   master : the environment driving/consuming the checker
// -----------------------------------------------------------------------------
interface dataint_parity_chk_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int CHUNKS = 4
) ();

    logic              i_valid;
    logic              o_ready;
    logic [WIDTH-1:0]  i_data;
    logic [CHUNKS-1:0] i_parity;

    logic              o_valid;
    logic              i_ready;
    logic [WIDTH-1:0]  o_data;
    logic [CHUNKS-1:0] o_error;

    modport slave (
        input  i_valid, i_data, i_parity, i_ready,
        output o_ready, o_valid, o_data, o_error
    );

    modport master (
        output i_valid, i_data, i_parity, i_ready,
        input  o_ready, o_valid, o_data, o_error
    );

endinterface

// File: rtl/dataint_parity_chunk_calc.sv
// -----------------------------------------------------------------------------
// dataint_parity_chunk_calc
// Purely combinational per-chunk parity recomputation and comparison.
//
// Ports:
//   i_data[WIDTH]         data word
//   i_parity[CHUNKS]      received parity, one bit per chunk
//   i_parity_type         PARITY_EVEN: expected = ^chunk, PARITY_ODD: ~^chunk
//   o_exp_parity[CHUNKS]  recomputed parity
//   o_error[CHUNKS]       1 where recomputed and received parity differ
// -----------------------------------------------------------------------------
module dataint_parity_chunk_calc
    import dataint_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CHUNKS = 4
) (
    input  logic [WIDTH-1:0]  i_data,
    input  logic [CHUNKS-1:0] i_parity,
    input  parity_type_e      i_parity_type,
    output logic [CHUNKS-1:0] o_exp_parity,
    output logic [CHUNKS-1:0] o_error
);

    for (genvar g = 0; g < CHUNKS; g++) begin : g_chunk
        localparam int Lo = chunk_lo(WIDTH, CHUNKS, g);
        localparam int Hi = chunk_hi(WIDTH, CHUNKS, g);

        logic w_chunk_xor;

        assign w_chunk_xor     = ^i_data[Hi:Lo];
        assign o_exp_parity[g] = (i_parity_type == PARITY_EVEN) ? w_chunk_xor : ~w_chunk_xor;
        assign o_error[g]      = o_exp_parity[g] ^ i_parity[g];
    end

endmodule

// File: rtl/dataint_parity_chk_pipe.sv
// -----------------------------------------------------------------------------
// dataint_parity_chk_pipe
// Receive-side chunked parity checker with one full-throughput pipeline stage
// and CSR-visible error status.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_parity_type         1=even, 0=odd; sampled with each accepted beat
//   if_bus (slave)        upstream/downstream valid/ready stream
//   i_clear               synchronous clear of status, counter and beat index
//   o_err_sticky          OR of chunk errors since reset/clear
//   o_err_count           saturating count of errored beats
//   o_first_err_valid     o_first_err_beat holds a captured value
//   o_first_err_beat      beat index of the first errored beat
// -----------------------------------------------------------------------------
module dataint_parity_chk_pipe
    import dataint_pkg::*;
#(
    parameter int CHUNKS    = 4,
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_parity_type,
    dataint_parity_chk_pipe_if.slave if_bus,
    input  logic                     i_clear,
    output logic [CHUNKS-1:0]        o_err_sticky,
    output logic [CNT_WIDTH-1:0]     o_err_count,
    output logic                     o_first_err_valid,
    output logic [CNT_WIDTH-1:0]     o_first_err_beat
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    // Pipeline stage
    logic                 r_valid;
    logic [WIDTH-1:0]     r_data;
    logic [CHUNKS-1:0]    r_error;

    // Status
    logic [CHUNKS-1:0]    r_sticky;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_beat_idx;
    logic                 r_first_valid;
    logic [CNT_WIDTH-1:0] r_first_beat;

    logic [CHUNKS-1:0]    w_error;
    logic [CHUNKS-1:0]    w_unused_exp_parity;
    logic                 w_accept;
    logic                 w_beat_err;

    logic [CHUNKS-1:0]    w_sticky_nxt;
    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic [CNT_WIDTH-1:0] w_beat_idx_nxt;
    logic                 w_first_valid_nxt;
    logic [CNT_WIDTH-1:0] w_first_beat_nxt;

    dataint_parity_chunk_calc #(
        .WIDTH  (WIDTH),
        .CHUNKS (CHUNKS)
    ) u_calc (
        .i_data        (if_bus.i_data),
        .i_parity      (if_bus.i_parity),
        .i_parity_type (parity_type_e'(i_parity_type)),
        .o_exp_parity  (w_unused_exp_parity),
        .o_error       (w_error)
    );

    // The stage can take a new beat whenever it is empty or its current beat
    // leaves this cycle, giving one beat per clock under continuous ready.
    assign if_bus.o_ready = ~r_valid | if_bus.i_ready;
    assign w_accept       = if_bus.i_valid & if_bus.o_ready;
    assign w_beat_err     = |w_error;

    assign if_bus.o_valid = r_valid;
    assign if_bus.o_data  = r_data;
    assign if_bus.o_error = r_error;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_error <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= if_bus.i_data;
            r_error <= w_error;
        end else if (if_bus.i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Clear is folded in first, then an accepted beat is recorded on top of
    // the cleared state, so a collision still logs the colliding beat.
    always_comb begin
        // NOTE: every output gets a default up front; a path that skipped an
        // assignment would otherwise infer a latch.
        w_sticky_nxt      = i_clear ? '0   : r_sticky;
        w_count_nxt       = i_clear ? '0   : r_count;
        w_beat_idx_nxt    = i_clear ? '0   : r_beat_idx;
        w_first_valid_nxt = i_clear ? 1'b0 : r_first_valid;
        w_first_beat_nxt  = i_clear ? '0   : r_first_beat;

        if (w_accept) begin
            if (w_beat_err) begin
                w_sticky_nxt = w_sticky_nxt | w_error;
                if (w_count_nxt != CntMax) begin
                    w_count_nxt = w_count_nxt + CntOne;
                end
                // Capture uses the index before this beat's increment.
                if (!w_first_valid_nxt) begin
                    w_first_valid_nxt = 1'b1;
                    w_first_beat_nxt  = w_beat_idx_nxt;
                end
            end
            w_beat_idx_nxt = w_beat_idx_nxt + CntOne;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sticky      <= '0;
            r_count       <= '0;
            r_beat_idx    <= '0;
            r_first_valid <= 1'b0;
            r_first_beat  <= '0;
        end else begin
            r_sticky      <= w_sticky_nxt;
            r_count       <= w_count_nxt;
            r_beat_idx    <= w_beat_idx_nxt;
            r_first_valid <= w_first_valid_nxt;
            r_first_beat  <= w_first_beat_nxt;
        end
    end

    assign o_err_sticky      = r_sticky;
    assign o_err_count       = r_count;
    assign o_first_err_valid = r_first_valid;
    assign o_first_err_beat  = r_first_beat;

endmodule

// File: tb/tb_dataint_parity_chk_pipe.sv
// -----------------------------------------------------------------------------
// tb_dataint_parity_chk_pipe
// Three checker instances share one stimulus stream:
//   dut 0 : WIDTH=32, CHUNKS=4, CNT_WIDTH=16
//   dut 1 : WIDTH=30, CHUNKS=4, CNT_WIDTH=16 (9-bit top chunk)
//   dut 2 : WIDTH=32, CHUNKS=4, CNT_WIDTH=4  (counter saturation / wrap)
// Each is compared against a bit-counting parity model, a beat queue and a
// plain-integer status model.
// -----------------------------------------------------------------------------
module tb_dataint_parity_chk_pipe;

    localparam int N = 3;
    localparam int W    [N] = '{32, 30, 32};
    localparam int CMAX [N] = '{65535, 65535, 15};
    localparam int IMOD [N] = '{65536, 65536, 16};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        t_valid, t_ready, t_ptype, t_clear;
    logic [31:0] t_data;
    logic [3:0]  t_par;

    dataint_parity_chk_pipe_if #(.WIDTH(32), .CHUNKS(4)) bus_a ();
    dataint_parity_chk_pipe_if #(.WIDTH(30), .CHUNKS(4)) bus_b ();
    dataint_parity_chk_pipe_if #(.WIDTH(32), .CHUNKS(4)) bus_c ();

    assign bus_a.i_valid = t_valid;  assign bus_a.i_ready = t_ready;
    assign bus_a.i_data  = t_data;   assign bus_a.i_parity = t_par;
    assign bus_b.i_valid = t_valid;  assign bus_b.i_ready = t_ready;
    assign bus_b.i_data  = t_data[29:0]; assign bus_b.i_parity = t_par;
    assign bus_c.i_valid = t_valid;  assign bus_c.i_ready = t_ready;
    assign bus_c.i_data  = t_data;   assign bus_c.i_parity = t_par;

    logic [3:0]  sticky_a, sticky_b, sticky_c;
    logic [15:0] cnt_a, cnt_b, fb_a, fb_b;
    logic [3:0]  cnt_c, fb_c;
    logic        fv_a, fv_b, fv_c;

    dataint_parity_chk_pipe #(.CHUNKS(4), .WIDTH(32), .CNT_WIDTH(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_parity_type(t_ptype), .if_bus(bus_a),
        .i_clear(t_clear), .o_err_sticky(sticky_a), .o_err_count(cnt_a),
        .o_first_err_valid(fv_a), .o_first_err_beat(fb_a)
    );
    dataint_parity_chk_pipe #(.CHUNKS(4), .WIDTH(30), .CNT_WIDTH(16)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_parity_type(t_ptype), .if_bus(bus_b),
        .i_clear(t_clear), .o_err_sticky(sticky_b), .o_err_count(cnt_b),
        .o_first_err_valid(fv_b), .o_first_err_beat(fb_b)
    );
    dataint_parity_chk_pipe #(.CHUNKS(4), .WIDTH(32), .CNT_WIDTH(4)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_parity_type(t_ptype), .if_bus(bus_c),
        .i_clear(t_clear), .o_err_sticky(sticky_c), .o_err_count(cnt_c),
        .o_first_err_valid(fv_c), .o_first_err_beat(fb_c)
    );

    // Uniform views of the three instances
    logic        o_ready_s [N], o_valid_s [N], fv_s [N];
    logic [31:0] o_data_s  [N];
    logic [3:0]  o_err_s   [N], sticky_s [N];
    logic [15:0] cnt_s     [N], fb_s     [N];

    assign o_ready_s[0] = bus_a.o_ready; assign o_ready_s[1] = bus_b.o_ready; assign o_ready_s[2] = bus_c.o_ready;
    assign o_valid_s[0] = bus_a.o_valid; assign o_valid_s[1] = bus_b.o_valid; assign o_valid_s[2] = bus_c.o_valid;
    assign o_data_s[0]  = bus_a.o_data;  assign o_data_s[1]  = {2'b00, bus_b.o_data}; assign o_data_s[2] = bus_c.o_data;
    assign o_err_s[0]   = bus_a.o_error; assign o_err_s[1]   = bus_b.o_error; assign o_err_s[2]   = bus_c.o_error;
    assign sticky_s[0]  = sticky_a;      assign sticky_s[1]  = sticky_b;      assign sticky_s[2]  = sticky_c;
    assign cnt_s[0]     = cnt_a;         assign cnt_s[1]     = cnt_b;         assign cnt_s[2]     = {12'd0, cnt_c};
    assign fb_s[0]      = fb_a;          assign fb_s[1]      = fb_b;          assign fb_s[2]      = {12'd0, fb_c};
    assign fv_s[0]      = fv_a;          assign fv_s[1]      = fv_b;          assign fv_s[2]      = fv_c;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0][31:0] d;
        logic [2:0][3:0]  e;
    } beat_t;

    beat_t       q[$];          // beats accepted but not yet handed downstream
    int          m_cnt    [N];
    int          m_beat   [N];
    int          m_fb     [N];
    bit          m_fv     [N];
    logic [3:0]  m_sticky [N];

    logic [31:0] dlv[$];        // dut 0 output data actually handed downstream
    bit          last_acc;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Expected parity per chunk by counting ones in each chunk's bit range.
    function automatic logic [3:0] ref_par(input logic [31:0] d, input int width, input bit even);
        logic [3:0] p;
        int cs, lo, hi, ones;
        p  = '0;
        cs = width / 4;
        for (int i = 0; i < 4; i++) begin
            lo   = i * cs;
            hi   = (i == 3) ? width - 1 : lo + cs - 1;
            ones = 0;
            for (int b = lo; b <= hi; b++) ones += int'(d[b]);
            p[i] = even ? (ones % 2 == 1) : (ones % 2 == 0);
        end
        return p;
    endfunction

    function automatic logic [31:0] mask_w(input logic [31:0] d, input int width);
        logic [31:0] m;
        m = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
        return d & m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int k);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed 0x%0h expected 0x%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = 0; m_beat[k] = 0; m_fb[k] = 0; m_fv[k] = 1'b0; m_sticky[k] = '0;
        end
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < N; k++) begin
            check("rst_o_valid", 32'(o_valid_s[k]), 32'd0, k);
            check("rst_o_ready", 32'(o_ready_s[k]), 32'd1, k);
            check("rst_o_data",  o_data_s[k],       32'd0, k);
            check("rst_o_error", 32'(o_err_s[k]),   32'd0, k);
            check("rst_sticky",  32'(sticky_s[k]),  32'd0, k);
            check("rst_count",   32'(cnt_s[k]),     32'd0, k);
            check("rst_fv",      32'(fv_s[k]),      32'd0, k);
            check("rst_fb",      32'(fb_s[k]),      32'd0, k);
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < N; k++) begin
            check("o_valid", 32'(o_valid_s[k]), 32'(q.size() != 0), k);
            if (q.size() != 0) begin
                check("o_data",  o_data_s[k],     q[0].d[k],      k);
                check("o_error", 32'(o_err_s[k]), 32'(q[0].e[k]), k);
            end
            check("sticky", 32'(sticky_s[k]), 32'(m_sticky[k]), k);
            check("count",  32'(cnt_s[k]),    32'(m_cnt[k]),    k);
            check("fv",     32'(fv_s[k]),     32'(m_fv[k]),     k);
            check("fb",     32'(fb_s[k]),     32'(m_fb[k]),     k);
        end
    endtask

    // One clock: drive at the falling edge, update the model for the coming
    // rising edge, then check outputs at the next falling edge.
    task automatic step(input bit v, input logic [31:0] d, input logic [3:0] p,
                        input bit ev, input bit clr, input bit rdy);
        bit          exp_rdy;
        beat_t       bt;
        logic [3:0]  e;
        logic [31:0] dm;
        t_valid = v; t_data = d; t_par = p; t_ptype = ev; t_clear = clr; t_ready = rdy;
        #1;
        exp_rdy = (q.size() == 0) || rdy;
        for (int k = 0; k < N; k++) check("o_ready", 32'(o_ready_s[k]), 32'(exp_rdy), k);
        if (o_valid_s[0] && rdy) dlv.push_back(o_data_s[0]);
        last_acc = v && exp_rdy;
        if (q.size() != 0 && rdy) void'(q.pop_front());
        bt = '0;
        for (int k = 0; k < N; k++) begin
            if (clr) begin
                m_cnt[k] = 0; m_beat[k] = 0; m_fb[k] = 0; m_fv[k] = 1'b0; m_sticky[k] = '0;
            end
            if (last_acc) begin
                dm = mask_w(d, W[k]);
                e  = ref_par(dm, W[k], ev) ^ p;
                bt.d[k] = dm;
                bt.e[k] = e;
                if (e != 4'd0) begin
                    m_sticky[k] = m_sticky[k] | e;
                    if (m_cnt[k] < CMAX[k]) m_cnt[k]++;
                    if (!m_fv[k]) begin
                        m_fv[k] = 1'b1;
                        m_fb[k] = m_beat[k];
                    end
                end
                m_beat[k] = (m_beat[k] + 1) % IMOD[k];
            end
        end
        if (last_acc) q.push_back(bt);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input bit clr);
        step(1'b0, 32'd0, 4'd0, 1'b1, clr, 1'b1);
    endtask

    logic [31:0] d_r;
    logic [31:0] bp_d [5];
    int          sent;

    initial begin
        t_valid = 1'b0; t_ready = 1'b1; t_ptype = 1'b1; t_clear = 1'b0;
        t_data = '0; t_par = '0;
        model_reset();

        // Power-on reset
        #1 rst_n = 1'b0;
        #1 check_reset_state();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Even parity, single set bit: matching then mismatching chunk 0
        step(1'b1, 32'h0000_0001, 4'b0001, 1'b1, 1'b0, 1'b1);
        check("even_clean_err", 32'(o_err_s[0]), 32'h0, 0);
        step(1'b1, 32'h0000_0001, 4'b0000, 1'b1, 1'b0, 1'b1);
        check("even_bad_err",    32'(o_err_s[0]),  32'h1, 0);
        check("even_bad_count",  32'(cnt_s[0]),    32'd1, 0);
        check("even_bad_fb",     32'(fb_s[0]),     32'd1, 0);
        check("even_bad_sticky", 32'(sticky_s[0]), 32'h1, 0);

        // Odd parity, bit 29 lands in the 9-bit top chunk of the 30-bit build
        step(1'b1, 32'h2000_0000, 4'b1111, 1'b0, 1'b0, 1'b1);
        check("odd_top_chunk", 32'(o_err_s[1]), 32'h8, 1);
        idle(1'b0);

        // Backpressure: 5 clean beats with a 3-cycle downstream stall
        dlv.delete();
        for (int i = 0; i < 5; i++) bp_d[i] = $urandom;
        sent = 0;
        for (int c = 0; c < 40 && sent < 5; c++) begin
            step(1'b1, bp_d[sent], ref_par(bp_d[sent], 32, 1'b1), 1'b1, 1'b0, !(c >= 2 && c < 5));
            if (last_acc) sent++;
        end
        idle(1'b0);
        idle(1'b0);
        check("bp_sent",  32'(sent),       32'd5, 0);
        check("bp_count", 32'(dlv.size()), 32'd5, 0);
        for (int i = 0; i < 5; i++) begin
            if (i < dlv.size()) check("bp_order", dlv[i], bp_d[i], 0);
        end

        // Saturation on the 4-bit counter build, then beat-index wrap
        idle(1'b1);
        for (int i = 0; i < 20; i++) begin
            d_r = $urandom;
            step(1'b1, d_r, ref_par(d_r, 32, 1'b1) ^ 4'($urandom_range(1, 15)), 1'b1, 1'b0, 1'b1);
        end
        idle(1'b0);
        check("sat_count", 32'(cnt_s[2]), 32'd15, 2);
        check("sat_fb",    32'(fb_s[2]),  32'd0,  2);
        check("sat_fv",    32'(fv_s[2]),  32'd1,  2);
        idle(1'b1);
        for (int i = 0; i < 20; i++) begin
            d_r = $urandom;
            step(1'b1, d_r, ref_par(d_r, 32, 1'b0), 1'b0, 1'b0, 1'b1);
        end
        d_r = $urandom;
        step(1'b1, d_r, ref_par(d_r, 32, 1'b0) ^ 4'b0100, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        check("wrap_fb",    32'(fb_s[2]),  32'd4, 2);
        check("wrap_count", 32'(cnt_s[2]), 32'd1, 2);

        // Clear colliding with an errored accept after count reached 7
        idle(1'b1);
        for (int i = 0; i < 7; i++) begin
            d_r = $urandom;
            step(1'b1, d_r, ref_par(d_r, 32, 1'b1) ^ 4'b0010, 1'b1, 1'b0, 1'b1);
        end
        idle(1'b0);
        check("pre_clr_count", 32'(cnt_s[0]), 32'd7, 0);
        d_r = $urandom;
        step(1'b1, d_r, ref_par(d_r, 32, 1'b1) ^ 4'b1001, 1'b1, 1'b1, 1'b1);
        check("clr_count",  32'(cnt_s[0]),    32'd1, 0);
        check("clr_fb",     32'(fb_s[0]),     32'd0, 0);
        check("clr_fv",     32'(fv_s[0]),     32'd1, 0);
        check("clr_sticky", 32'(sticky_s[0]), 32'h9, 0);

        // Randomized traffic: random valid/ready/parity type/clear
        for (int i = 0; i < 80; i++) begin
            step(($urandom % 4) != 0, $urandom, 4'($urandom), 1'($urandom), ($urandom % 16) == 0,
                 ($urandom % 3) != 0);
        end

        // Asynchronous reset in the middle of a stall
        d_r = $urandom;
        step(1'b1, d_r, 4'($urandom), 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        check("stall_valid", 32'(o_valid_s[0]), 32'd1, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_state();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(($urandom % 2) != 0, $urandom, 4'($urandom), 1'($urandom), 1'b0, ($urandom % 2) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dataint_parity_chk_pipe.md
Name: dataint_parity_chk_pipe

Overview:
Receive-side parity checker for a valid/ready data stream. Each beat carries data plus one parity bit per chunk.
- Recomputes chunk parity and flags per-chunk mismatches.
- Registers data and flags through one pipeline stage at full throughput.
- Keeps sticky error status, a saturating error-beat counter and first-error beat capture for CSR readout.
- Sits at the sink of any datapath protected by the team's chunked parity generator.

Parameters:
CHUNKS, 4, number of parity chunks
WIDTH, 32, total data width; CHUNKS <= WIDTH
CNT_WIDTH, 16, width of error counter and beat index

Ports:
i_clk  input  1  clock, all logic rising-edge
i_rst_n  input  1  reset, asynchronous, active-low
i_parity_type  input  1  1=even, 0=odd; the expected parity bit is ^chunk for even and ~^chunk for odd
i_valid  input  1  upstream beat valid
o_ready  output  1  upstream ready
i_data  input  WIDTH  upstream data
i_parity  input  CHUNKS  received parity, one bit per chunk
o_valid  output  1  downstream beat valid
i_ready  input  1  downstream ready
o_data  output  WIDTH  registered data
o_error  output  CHUNKS  registered per-chunk mismatch for the o_data beat
i_clear  input  1  synchronous clear of status/counters
o_err_sticky  output  CHUNKS  OR of all chunk errors since reset/clear
o_err_count  output  CNT_WIDTH  count of errored beats, saturating
o_first_err_valid  output  1  first_err_beat holds a captured value
o_first_err_beat  output  CNT_WIDTH  beat index of the first errored beat

Behaviour:
- Chunking: ChunkSize = WIDTH/CHUNKS.
  - Chunk i covers bits [(i+1)*ChunkSize-1 : i*ChunkSize].
  - The last chunk extends to WIDTH-1 and absorbs the remainder bits.
- Mismatch: error[i] = (expected parity[i] != i_parity[i]), computed combinationally from the input beat.
- Accept: accept = i_valid & o_ready.
  - o_ready = ~o_valid | i_ready, so a full pipe with i_ready high accepts a new beat every cycle.
- Latency: a beat accepted at edge N appears on o_data/o_error with o_valid=1 after edge N.
- Output stage:
  - On accept, load o_data, o_error and set o_valid.
  - If i_ready and no accept, clear o_valid.
  - While stalled (o_valid & ~i_ready), o_data/o_error hold stable and o_ready=0.
- i_parity_type is sampled at accept. A change only affects beats accepted afterwards.
- Beat index: CNT_WIDTH counter, incremented on every accept, wraps to 0 at all-ones.
- Status updates happen at accept, not at output:
  - An errored beat (|error) ORs error into o_err_sticky.
  - An errored beat increments o_err_count by 1, regardless of how many chunks failed.
  - o_err_count saturates at all-ones and does not wrap.
  - On the first errored beat, o_first_err_beat is set to the current beat index (the pre-increment value) and o_first_err_valid is set to 1. Later errored beats do not overwrite it.
- i_clear zeroes sticky, count, first_err_valid, first_err_beat and the beat index. It does not touch the pipeline register or o_valid.
- i_clear coinciding with an accepted errored beat:
  - The clear is applied first, then the beat is recorded.
  - Result: count=1, sticky=that beat's error, first_err_beat=0, first_err_valid=1, beat index=1.
- Reset (any time, including mid-stall) drives every output and internal register to 0:
  - o_valid=0, o_data=0, o_error=0, sticky=0, count=0, first_err_valid=0, first_err_beat=0, beat index=0.
  - o_ready reads 1 during and after reset.
- The input beat is dropped only if not accepted. There is no internal FIFO; the upstream must hold i_data/i_parity while i_valid & ~o_ready.

Decomposition:
- Shared package dataint_pkg:
  - typedef parity_type_e (PARITY_ODD=1'b0, PARITY_EVEN=1'b1).
  - Function for chunk upper/lower bounds, so that generator and checker agree.
- One sub-module, dataint_parity_chunk_calc (combinational): inputs data, parity, type; outputs per-chunk expected parity and error vector. The top level holds the pipeline register, counters and status.

Test Plan:
- Even, WIDTH=32, CHUNKS=4: i_data=0x0000_0001 with i_parity=4'b0001, then with 4'b0000 -> first beat o_error=0; second beat o_error=4'b0001, o_err_count=1, o_first_err_beat=1, sticky=4'b0001.
- Odd, WIDTH=30, CHUNKS=4 (chunk3 = bits 29:21): i_data=0x2000_0000, i_parity=4'b1111 -> o_error=4'b1000, i.e. the error lands in the 9-bit last chunk.
- Backpressure: stream 5 clean beats with i_ready low for 3 cycles mid-stream -> o_ready low while stalled, o_data held constant, all 5 beats delivered in order, none lost or duplicated.
- Saturation, CNT_WIDTH=4: 20 back-to-back errored beats -> o_err_count=15 and holds; o_first_err_beat=0; beat index wraps to 4.
- Clear collision: raise i_clear in the same cycle as an errored accept after count=7 -> count=1, first_err_beat=0, first_err_valid=1.
- Async reset asserted mid-stall with o_valid=1 -> o_valid, o_error and all status go to 0 immediately, without a clock edge; o_ready=1 after release.
